// File: rtl/gpu_copy_engine.sv
// Purpose: framebuffer copy/scroll/fill engine with a memory-mapped register bank.
// Latency: register reads return one cycle after read; copy/scroll take DEPTH+1 cycles, fill DEPTH cycles.
// Backpressure: none; CHARS accesses and CONTROL/FILL/SCROLL writes that arrive while busy are dropped and flag err.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   address/write_data/read/write bus request; address[63:56] selects the device, address[10:0] is the offset
//   read_data                     registered read return (CHARS reads pass the external word one cycle later)
//   vblank                        vertical blank, already synchronous to clock
//   ext_addr/ext_wdata/ext_we     external framebuffer port, ext_rdata has 1-cycle read latency
//   ext_rdata
//   int_addr/int_wdata/int_we     internal framebuffer write port
//   busy, done_irq                engine active; one-cycle completion pulse
module gpu_copy_engine #(
    parameter int         DATA_WIDTH = 64,
    parameter int         DEPTH      = 1200,
    parameter int         FB_AW      = 11,
    parameter logic [7:0] DEVICE_ID  = 8'h02
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [63:0]           address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read,
    input  logic                  write,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  vblank,
    output logic [FB_AW-1:0]      ext_addr,
    output logic [DATA_WIDTH-1:0] ext_wdata,
    output logic                  ext_we,
    input  logic [DATA_WIDTH-1:0] ext_rdata,
    output logic [FB_AW-1:0]      int_addr,
    output logic [DATA_WIDTH-1:0] int_wdata,
    output logic                  int_we,
    output logic                  busy,
    output logic                  done_irq
);

    typedef enum logic [1:0] {IDLE, WAIT_VB, RUN, FLUSH} stateT;

    localparam logic [1:0]            MODE_NONE   = 2'b00;
    localparam logic [1:0]            MODE_FILL   = 2'b10;
    localparam logic [1:0]            MODE_SCROLL = 2'b11;
    localparam logic [FB_AW-1:0]      K_LAST      = FB_AW'(DEPTH - 1);
    localparam logic [FB_AW:0]        DEPTH_W     = (FB_AW + 1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] DEPTH_D     = DATA_WIDTH'(DEPTH);
    localparam logic [11:0]           CHARS_END   = 12'(8 + DEPTH);

    stateT                  state, stateNext;
    logic [1:0]             ctrlMode, opMode;
    logic                   ctrlWaitVb, ctrlStart;
    logic [DATA_WIDTH-1:0]  fillReg, scrollReg;
    logic [FB_AW-1:0]       scrollMod;
    logic [FB_AW-1:0]       k, kPrev;
    logic                   rdPend;
    logic                   doneFlag, errFlag, doneIrq;
    logic [DATA_WIDTH-1:0]  readReg, readNext;
    logic                   charsRdPend;
    logic                   finish;

    // ---------------- address decode ----------------
    logic        selected;
    logic [10:0] offset;
    logic        isCtrl, isStatus, isFill, isScroll, isChars;
    logic        engineBusy, charsIdle, cfgWrite, statusWr, errSet;
    logic [FB_AW-1:0] charIndex;

    assign selected   = (address[63:56] == DEVICE_ID);
    assign offset     = address[10:0];
    assign isCtrl     = selected && (offset == 11'd0);
    assign isStatus   = selected && (offset == 11'd2);
    assign isFill     = selected && (offset == 11'd3);
    assign isScroll   = selected && (offset == 11'd4);
    assign isChars    = selected && ({1'b0, offset} >= 12'd8) && ({1'b0, offset} < CHARS_END);
    assign charIndex  = FB_AW'(offset - 11'd8);

    assign engineBusy = (state != IDLE);
    assign charsIdle  = isChars && !engineBusy;
    assign cfgWrite   = write && (isCtrl || isFill || isScroll);
    assign statusWr   = write && isStatus;
    assign errSet     = engineBusy && (cfgWrite || ((read || write) && isChars));

    // ---------------- scroll source address ----------------
    // One extra bit keeps k+scroll from overflowing; a single conditional
    // subtract wraps it since both operands are already below DEPTH.
    logic [FB_AW:0]   scrollSum, scrollSub;
    logic [FB_AW-1:0] scrollAddr;
    logic             runExt;

    assign scrollSum  = {1'b0, k} + {1'b0, scrollMod};
    assign scrollSub  = scrollSum - DEPTH_W;
    assign scrollAddr = (scrollSum >= DEPTH_W) ? scrollSub[FB_AW-1:0] : scrollSum[FB_AW-1:0];
    assign runExt     = (state == RUN) && (opMode != MODE_FILL);

    logic unusedBits;
    assign unusedBits = ^{address[55:11], scrollSub[FB_AW]};

    // ---------------- FSM next state and datapath outputs ----------------
    always_comb begin
        stateNext = state;
        finish    = 1'b0;
        ext_we    = 1'b0;
        ext_addr  = charIndex;
        ext_wdata = write_data;
        int_we    = 1'b0;
        int_addr  = k;
        int_wdata = fillReg;

        unique case (state)
            IDLE: begin
                if (ctrlStart && ctrlMode != MODE_NONE)
                    stateNext = ctrlWaitVb ? WAIT_VB : RUN;
            end
            WAIT_VB: begin
                if (vblank)
                    stateNext = RUN;
            end
            RUN: begin
                if (k == K_LAST) begin
                    if (opMode == MODE_FILL) begin
                        stateNext = IDLE;
                        finish    = 1'b1;
                    end else begin
                        stateNext = FLUSH;
                    end
                end
            end
            FLUSH: begin
                stateNext = IDLE;
                finish    = 1'b1;
            end
            default: stateNext = IDLE;
        endcase

        // Bus CHARS writes only reach the external port while idle.
        if (charsIdle && write)
            ext_we = 1'b1;

        if (runExt)
            ext_addr = (opMode == MODE_SCROLL) ? scrollAddr : k;

        // Copy/scroll: write back the word fetched last cycle.
        if (rdPend) begin
            int_we    = 1'b1;
            int_addr  = kPrev;
            int_wdata = ext_rdata;
        end else if (state == RUN && opMode == MODE_FILL) begin
            int_we    = 1'b1;
            int_addr  = k;
            int_wdata = fillReg;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        readNext = '0;
        if (read) begin
            if (isCtrl)
                readNext = {{(DATA_WIDTH-4){1'b0}}, ctrlStart, ctrlWaitVb, ctrlMode};
            else if (isStatus)
                readNext = {{(DATA_WIDTH-3){1'b0}}, errFlag, doneFlag, engineBusy};
            else if (isFill)
                readNext = fillReg;
            else if (isScroll)
                readNext = scrollReg;
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            opMode      <= MODE_NONE;
            ctrlMode    <= MODE_NONE;
            ctrlWaitVb  <= 1'b0;
            ctrlStart   <= 1'b0;
            fillReg     <= '0;
            scrollReg   <= '0;
            scrollMod   <= '0;
            k           <= '0;
            kPrev       <= '0;
            rdPend      <= 1'b0;
            doneFlag    <= 1'b0;
            errFlag     <= 1'b0;
            doneIrq     <= 1'b0;
            readReg     <= '0;
            charsRdPend <= 1'b0;
        end else begin
            state <= stateNext;

            // Latch the mode at launch so a CONTROL write landing in the
            // start-pending cycle cannot change the running operation.
            if (state == IDLE && stateNext != IDLE)
                opMode <= ctrlMode;

            if (state == RUN)
                k <= (k == K_LAST) ? '0 : k + 1'b1;
            else
                k <= '0;

            kPrev   <= k;
            rdPend  <= runExt;
            doneIrq <= finish;

            ctrlStart <= 1'b0;
            if (cfgWrite && !engineBusy) begin
                if (isCtrl)
                    {ctrlStart, ctrlWaitVb, ctrlMode} <= write_data[3:0];
                if (isFill)
                    fillReg <= write_data;
                if (isScroll) begin
                    scrollReg <= write_data;
                    scrollMod <= FB_AW'(write_data % DEPTH_D);
                end
            end

            // Completion beats a simultaneous clear.
            if (finish)
                doneFlag <= 1'b1;
            else if (statusWr && write_data[1])
                doneFlag <= 1'b0;

            if (errSet)
                errFlag <= 1'b1;
            else if (statusWr && write_data[2])
                errFlag <= 1'b0;

            readReg     <= readNext;
            charsRdPend <= read && charsIdle;
        end
    end

    assign read_data = charsRdPend ? ext_rdata : readReg;
    assign busy      = engineBusy;
    assign done_irq  = doneIrq;

endmodule
